uart_echo_checker: RTL
======================

# uart_echo_checker

Initiator for the UART echo path. It drives a buart transmit port with a repeating printable-ASCII sequence and reads each echoed byte back from the buart receive port. It compares every echo against the byte sent, and counts passes, mismatches and timeouts. It sits beside `buart` in a tester top and exercises a remote loopback device over `txd`/`rxd`.

## Interface
- `START_CHAR`, 8'h20: first byte of the sequence and its wrap target.
- `END_CHAR`, 8'h7E: last byte before wrap. Must be ≥ `START_CHAR`.
- `TIMEOUT_CYCLES`, 600_000: number of cycles to wait for an echo (10 ms at 60 MHz). Must be ≥ 2.
- `clk` in 1: system clock, the 60 MHz PLL output.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level input; run the test while high.
- `uart_wr` out 1: one-cycle write strobe to buart `wr`.
- `tx_data` out 8: byte to transmit, connected to buart `tx_data`.
- `tx_busy` in 1: buart `busy`.
- `uart_rd` out 1: one-cycle read strobe to buart `rd`.
- `rx_valid` in 1: buart `valid`.
- `rx_data` in 8: buart `rx_data`.
- `running` out 1: high whenever the FSM is not in IDLE.
- `pass_count` out 16: number of matching echoes; saturates at 16'hFFFF.
- `err_count` out 16: mismatches plus stray bytes; saturates at 16'hFFFF.
- `timeout_count` out 8: number of missing echoes; saturates at 8'hFF.
- `last_bad` out 8: most recent mismatching received byte.

## Operation
- All outputs are registered.
- **Reset values:** `uart_wr`=0, `uart_rd`=0, `tx_data`=`START_CHAR`, `running`=0, all counts=0, `last_bad`=0, state=IDLE, timeout timer=0.
- **Reset mid-operation:** reset takes effect immediately (asynchronous). It abandons any byte in flight, and the sequence restarts at `START_CHAR`.

**IDLE**
- If `rx_valid`, pulse `uart_rd` and discard the byte without counting it. Then pass through DRAIN before looking at `enable`.
- Otherwise, if `enable` is high, go to SEND.

**SEND**
- If `rx_valid`, pulse `uart_rd`, increment `err_count`, set `last_bad`=`rx_data`, go to DRAIN, then return to SEND.
- Otherwise, if `!tx_busy`, pulse `uart_wr` with `tx_data` stable, clear the timer, and go to WAIT_ECHO.
- `tx_busy` is not sampled until the next SEND.

**WAIT_ECHO**
- The timer increments every cycle.
- If `rx_valid`:
  - Pulse `uart_rd` and compare `rx_data` with `tx_data`.
  - On a match, increment `pass_count`.
  - On a mismatch, increment `err_count` and set `last_bad`=`rx_data`.
  - Go to ADVANCE.
- Otherwise, if the timer reaches `TIMEOUT_CYCLES`-1, increment `timeout_count` and go to ADVANCE.
- If `rx_valid` arrives in the same cycle as expiry, the echo wins and no timeout is counted.

**ADVANCE** (one cycle)
- `uart_rd` returns low and `rx_valid` is ignored, covering buart's one-cycle valid clear.
- Update `tx_data`: if it equals `END_CHAR`, load `START_CHAR`; otherwise increment it.
- Next state is SEND if `enable` is high, else IDLE.

**DRAIN** (one cycle)
- `rx_valid` is ignored.
- Return to the state that entered DRAIN.

**`enable` behaviour**
- Dropping `enable` mid-byte does not abort. The current byte completes with an echo or timeout, then the FSM goes to IDLE.
- `tx_data` keeps its next value, so re-enabling continues the sequence.

**`running`** is registered and equals (next state != IDLE).

## Timing
- `enable` high in IDLE with `tx_busy` low: `uart_wr` is high 2 cycles later (IDLE→SEND, then the strobe). It stays high for exactly 1 cycle.
- `rx_valid` seen in WAIT_ECHO at cycle N:
  - `uart_rd` is high at N+1 for 1 cycle.
  - The counter update is visible at N+1.
  - `tx_data` advances at N+2.
  - The next `uart_wr` comes no earlier than N+3.
- Timeout: when no echo arrives, `timeout_count` updates exactly `TIMEOUT_CYCLES` cycles after the `uart_wr` strobe.
- `uart_wr` and `uart_rd` are never high in the same cycle. Neither is ever high for two consecutive cycles.

## Test plan
- **Echo model:** model buart as a wr→rx_valid echo after 50 cycles. `enable`=1 for 3 bytes → `tx_data` 8'h20, 8'h21, 8'h22; `pass_count`=3; `err_count`=0.
- **Wrap:** `START_CHAR`=8'h41, `END_CHAR`=8'h43, 5 echoes → bytes sent are 41,42,43,41,42; `pass_count`=5.
- **Corrupted echo:** the echo model flips bit 0 on the 2nd byte (returns 8'h20 for 8'h21) → `err_count`=1, `last_bad`=8'h20, `pass_count`=2 after 3 bytes.
- **Timeout:** `TIMEOUT_CYCLES`=100, no echo → `timeout_count` increments at wr+100. The sequence advances to 8'h21. A `rx_valid` that coincides with the expiry cycle counts as a pass, not a timeout.
- **Busy and enable-drop:** hold `tx_busy` high for 200 cycles → `uart_wr` is withheld until it falls. Drop `enable` during WAIT_ECHO → the echo is still counted, the FSM enters IDLE, and `running`=0.
- **Stray byte and reset:** a stray `rx_valid` during SEND → one `uart_rd` pulse and `err_count`+1. Assert `reset` mid-WAIT_ECHO → all outputs take their reset values in the same cycle, and `tx_data`=8'h20.

Source files
------------

// File: rtl/uart_echo_checker.sv
// uart_echo_checker: drives a buart transmitter with a repeating
// printable-ASCII sequence and checks every echoed byte that comes back on
// the buart receiver. It counts matching echoes, mismatches and stray
// bytes, and echoes that never arrived. Every output is a register.

module uart_echo_checker #(
    parameter logic [7:0]  START_CHAR     = 8'h20,
    parameter logic [7:0]  END_CHAR       = 8'h7E,
    parameter int unsigned TIMEOUT_CYCLES = 600_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        uart_wr,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        uart_rd,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        running,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [7:0]  timeout_count,
    output logic [7:0]  last_bad
);

    // The timer only has to count up to TIMEOUT_CYCLES-1.
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ECHO,
        ADVANCE,
        DRAIN
    } state_t;

    state_t             state;
    state_t             drain_ret;
    logic [TIMER_W-1:0] timer;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Main controller: sequencing, strobes, echo comparison and counters.
    // running is loaded with (next state != IDLE) alongside each transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            drain_ret     <= IDLE;
            timer         <= '0;
            uart_wr       <= 1'b0;
            uart_rd       <= 1'b0;
            tx_data       <= START_CHAR;
            running       <= 1'b0;
            pass_count    <= 16'd0;
            err_count     <= 16'd0;
            timeout_count <= 8'd0;
            last_bad      <= 8'd0;
        end else begin
            uart_wr <= 1'b0;
            uart_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        uart_rd   <= 1'b1;
                        drain_ret <= IDLE;
                        state     <= DRAIN;
                        running   <= 1'b1;
                    end else if (enable) begin
                        state   <= SEND;
                        running <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
                SEND: begin
                    running <= 1'b1;
                    if (rx_valid) begin
                        uart_rd   <= 1'b1;
                        err_count <= sat_inc16(err_count);
                        last_bad  <= rx_data;
                        drain_ret <= SEND;
                        state     <= DRAIN;
                    end else if (!tx_busy) begin
                        uart_wr <= 1'b1;
                        timer   <= '0;
                        state   <= WAIT_ECHO;
                    end
                end
                WAIT_ECHO: begin
                    running <= 1'b1;
                    timer   <= timer + TIMER_W'(1);
                    if (rx_valid) begin
                        uart_rd <= 1'b1;
                        if (rx_data == tx_data) begin
                            pass_count <= sat_inc16(pass_count);
                        end else begin
                            err_count <= sat_inc16(err_count);
                            last_bad  <= rx_data;
                        end
                        state <= ADVANCE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_count <= sat_inc8(timeout_count);
                        state         <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    tx_data <= (tx_data == END_CHAR) ? START_CHAR : tx_data + 8'd1;
                    if (enable) begin
                        state   <= SEND;
                        running <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                DRAIN: begin
                    state   <= drain_ret;
                    running <= (drain_ret != IDLE);
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
